// File: rtl/tetris_pkg.sv
// Shared definitions for the falling-piece sprite path.
// Contents:
//   piece_t         - piece type / sprite select encoding
//   upd_state_t     - update handshake FSM states
//   SPR_W_* SPR_H_* - sprite width/height per piece type
//   spr_w / spr_h   - size lookup by piece type (NONE is 0x0)
//   TRANSPARENT_IDX - color index that never draws
package tetris_pkg;

  localparam int unsigned COORD_W = 10;
  localparam int unsigned OFS_W   = 6;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned SIZE_W  = 7;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    I_H  = 2'd1,
    I_V  = 2'd2,
    O    = 2'd3
  } piece_t;

  typedef enum logic {
    UPD_EMPTY   = 1'b0,
    UPD_PENDING = 1'b1
  } upd_state_t;

  localparam int unsigned SPR_W_I_H = 64;
  localparam int unsigned SPR_H_I_H = 16;
  localparam int unsigned SPR_W_I_V = 16;
  localparam int unsigned SPR_H_I_V = 64;
  localparam int unsigned SPR_W_O   = 32;
  localparam int unsigned SPR_H_O   = 32;

  localparam logic [IDX_W-1:0] TRANSPARENT_IDX = 3'd0;

  function automatic logic [SIZE_W-1:0] spr_w(piece_t t);
    case (t)
      I_H:     return SIZE_W'(SPR_W_I_H);
      I_V:     return SIZE_W'(SPR_W_I_V);
      O:       return SIZE_W'(SPR_W_O);
      default: return '0;
    endcase
  endfunction

  function automatic logic [SIZE_W-1:0] spr_h(piece_t t);
    case (t)
      I_H:     return SIZE_W'(SPR_H_I_H);
      I_V:     return SIZE_W'(SPR_H_I_V);
      O:       return SIZE_W'(SPR_H_O);
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/sprite_bbox.sv
// Combinational bounding-box test for one sprite placed at (x, y).
// Ports:
//   piece          in  2   piece type (piece_t encoding)
//   x, y           in  10  top-left corner of the sprite
//   draw_x, draw_y in  10  pixel coordinate under test
//   in_box         out 1   pixel lies inside the sprite rectangle
//   row, col       out 6   offset of the pixel inside the sprite (low bits)
// Arithmetic is 11 bits wide so x+W never wraps back onto the left edge.
module sprite_bbox
  import tetris_pkg::*;
(
  input  logic [1:0] piece,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic [9:0] draw_x,
  input  logic [9:0] draw_y,
  output logic       in_box,
  output logic [5:0] row,
  output logic [5:0] col
);

  piece_t      kind;
  logic [10:0] dx;
  logic [10:0] dy;
  logic [10:0] x_lo;
  logic [10:0] x_hi;
  logic [10:0] y_lo;
  logic [10:0] y_hi;

  always_comb begin
    kind   = piece_t'(piece);
    dx     = {1'b0, draw_x};
    dy     = {1'b0, draw_y};
    x_lo   = {1'b0, x};
    y_lo   = {1'b0, y};
    x_hi   = x_lo + 11'(spr_w(kind));
    y_hi   = y_lo + 11'(spr_h(kind));
    in_box = (kind != NONE) && (dx >= x_lo) && (dx < x_hi)
                            && (dy >= y_lo) && (dy < y_hi);
    // Only meaningful when in_box; sprites are at most 64 wide/high.
    col    = 6'(draw_x - x);
    row    = 6'(draw_y - y);
  end

endmodule

// File: rtl/sprite_draw_ctrl.sv
// Per-pixel controller for the falling-piece sprite.
// Ports:
//   Clk, Reset           pixel clock, synchronous active-high reset
//   frame_start          one-cycle pulse at start of vertical blank
//   pix_valid, DrawX/Y   pixel coordinate stream
//   upd_valid/upd_ready  handshake for a new piece state (type, x, y)
//   upd_type/x/y         offered piece state
//   spr_sel/row/col      registered address into the external sprite mux
//   spr_pix              color index returned combinationally by the mux
//   out_valid/hit/idx    registered result, two cycles after the coordinate
//   commit               one-cycle pulse when a pending update is applied
module sprite_draw_ctrl
  import tetris_pkg::*;
#(
  parameter int unsigned SCREEN_W = 640,
  parameter int unsigned SCREEN_H = 480
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_start,
  input  logic       pix_valid,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic       upd_valid,
  output logic       upd_ready,
  input  logic [1:0] upd_type,
  input  logic [9:0] upd_x,
  input  logic [9:0] upd_y,
  output logic [1:0] spr_sel,
  output logic [5:0] spr_row,
  output logic [5:0] spr_col,
  input  logic [2:0] spr_pix,
  output logic       out_valid,
  output logic       out_hit,
  output logic [2:0] out_idx,
  output logic       commit
);

  upd_state_t  state;
  piece_t      shadow_type;
  logic [9:0]  shadow_x;
  logic [9:0]  shadow_y;
  piece_t      active_type;
  logic [9:0]  active_x;
  logic [9:0]  active_y;

  logic        box_hit;
  logic        box_vis;
  logic [5:0]  box_row;
  logic [5:0]  box_col;
  logic        s1_valid;
  logic        s1_in_box;
  logic        pix_hit;

  // Update handshake: shadow loads on accept, active only moves on frame_start.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= UPD_EMPTY;
      upd_ready   <= 1'b1;
      commit      <= 1'b0;
      shadow_type <= NONE;
      shadow_x    <= '0;
      shadow_y    <= '0;
      active_type <= NONE;
      active_x    <= '0;
      active_y    <= '0;
    end else begin
      commit <= 1'b0;
      case (state)
        UPD_EMPTY: begin
          // frame_start in this same cycle is ignored; it waits for the next one.
          if (upd_valid) begin
            shadow_type <= piece_t'(upd_type);
            shadow_x    <= upd_x;
            shadow_y    <= upd_y;
            state       <= UPD_PENDING;
            upd_ready   <= 1'b0;
          end
        end
        UPD_PENDING: begin
          if (frame_start) begin
            active_type <= shadow_type;
            active_x    <= shadow_x;
            active_y    <= shadow_y;
            commit      <= 1'b1;
            state       <= UPD_EMPTY;
            upd_ready   <= 1'b1;
          end
        end
        default: begin
          state     <= UPD_EMPTY;
          upd_ready <= 1'b1;
        end
      endcase
    end
  end

  sprite_bbox u_bbox (
    .piece  (active_type),
    .x      (active_x),
    .y      (active_y),
    .draw_x (DrawX),
    .draw_y (DrawY),
    .in_box (box_hit),
    .row    (box_row),
    .col    (box_col)
  );

  // Clip to the visible screen so off-screen parts of a piece never draw.
  always_comb begin
    box_vis = box_hit
           && ({1'b0, DrawX} < 11'(SCREEN_W))
           && ({1'b0, DrawY} < 11'(SCREEN_H));
    pix_hit = s1_in_box && (spr_pix != TRANSPARENT_IDX);
  end

  // Stage 1 addresses the sprite mux, stage 2 captures its answer.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_valid  <= 1'b0;
      s1_in_box <= 1'b0;
      spr_sel   <= 2'd0;
      spr_row   <= '0;
      spr_col   <= '0;
      out_valid <= 1'b0;
      out_hit   <= 1'b0;
      out_idx   <= TRANSPARENT_IDX;
    end else begin
      s1_valid  <= pix_valid;
      s1_in_box <= box_vis;
      spr_sel   <= box_vis ? 2'(active_type) : 2'd0;
      spr_row   <= box_vis ? box_row : 6'd0;
      spr_col   <= box_vis ? box_col : 6'd0;
      out_valid <= s1_valid;
      out_hit   <= pix_hit;
      out_idx   <= pix_hit ? spr_pix : TRANSPARENT_IDX;
    end
  end

endmodule

// File: tb/tb_sprite_draw_ctrl.sv
// Self-checking bench for sprite_draw_ctrl: directed test-plan steps plus
// randomized line streaming against a pixel-level reference model.
module tb_sprite_draw_ctrl;

  logic       Clk = 1'b0;
  logic       rst, fs, pv, uv;
  logic [9:0] dx, dy, ux, uy;
  logic [1:0] ut;
  logic       upd_ready;
  logic [1:0] spr_sel;
  logic [5:0] spr_row, spr_col;
  logic [2:0] spr_pix;
  logic       out_valid, out_hit, commit;
  logic [2:0] out_idx;

  int errors = 0;
  int checks = 0;

  always #5 Clk = ~Clk;

  sprite_draw_ctrl #(.SCREEN_W(640), .SCREEN_H(480)) dut (
    .Clk         (Clk),
    .Reset       (rst),
    .frame_start (fs),
    .pix_valid   (pv),
    .DrawX       (dx),
    .DrawY       (dy),
    .upd_valid   (uv),
    .upd_ready   (upd_ready),
    .upd_type    (ut),
    .upd_x       (ux),
    .upd_y       (uy),
    .spr_sel     (spr_sel),
    .spr_row     (spr_row),
    .spr_col     (spr_col),
    .spr_pix     (spr_pix),
    .out_valid   (out_valid),
    .out_hit     (out_hit),
    .out_idx     (out_idx),
    .commit      (commit)
  );

  // Sprite artwork: 16x16 blocks, border 7, one transparent pixel per block,
  // fill 1 for I_V and 2 otherwise. Select 0 returns junk that must not leak.
  function automatic int spr_rom(int sel, int row, int col);
    int r = row % 16;
    int c = col % 16;
    if (sel == 0) return 5;
    if (row == 0 || col == 0 || r == 15 || c == 15) return 7;
    if (r == 7 && c == 7) return 0;
    return (sel == 2) ? 1 : 2;
  endfunction

  always_comb spr_pix = 3'(spr_rom(int'(spr_sel), int'(spr_row), int'(spr_col)));

  typedef struct {
    bit valid;
    bit inb;
    bit hit;
    int idx;
    int row;
    int col;
    int sel;
    int px;
    int py;
  } pix_t;

  // Reference: what the screen should show at (x, y) for a piece at (ox, oy).
  function automatic pix_t model_pix(int t, int ox, int oy, int x, int y);
    pix_t r;
    int w = 0;
    int h = 0;
    case (t)
      1: begin w = 64; h = 16; end
      2: begin w = 16; h = 64; end
      3: begin w = 32; h = 32; end
      default: begin w = 0; h = 0; end
    endcase
    r = '{default: 0};
    r.px  = x;
    r.py  = y;
    r.inb = (t != 0) && x >= ox && x < ox + w && y >= oy && y < oy + h
            && x < 640 && y < 480;
    r.row = r.inb ? y - oy : 0;
    r.col = r.inb ? x - ox : 0;
    r.sel = r.inb ? t : 0;
    r.idx = r.inb ? spr_rom(t, r.row, r.col) : 0;
    r.hit = (r.idx != 0);
    return r;
  endfunction

  // Model of piece state as seen by the pixel path.
  int   m_type = 0, m_x = 0, m_y = 0;
  int   s_type = 0, s_x = 0, s_y = 0;
  bit   m_pending = 0;
  bit   m_commit = 0;
  pix_t hist0 = '{default: 0};
  pix_t hist1 = '{default: 0};

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: predict, advance, compare the always-checkable outputs.
  task automatic cycle();
    pix_t e;
    e = model_pix(m_type, m_x, m_y, int'(dx), int'(dy));
    e.valid = pv;
    @(posedge Clk);
    #1;
    if (rst) begin
      m_pending = 0; m_commit = 0;
      s_type = 0; s_x = 0; s_y = 0;
      m_type = 0; m_x = 0; m_y = 0;
      hist0 = '{default: 0};
      hist1 = '{default: 0};
    end else begin
      hist1 = hist0;
      hist0 = e;
      m_commit = 0;
      if (!m_pending) begin
        if (uv) begin
          s_type = int'(ut); s_x = int'(ux); s_y = int'(uy);
          m_pending = 1;
        end
      end else if (fs) begin
        m_type = s_type; m_x = s_x; m_y = s_y;
        m_commit = 1;
        m_pending = 0;
      end
    end
    chk("out_valid", out_valid, hist1.valid);
    if (hist1.valid) begin
      chk($sformatf("out_hit@(%0d,%0d)", hist1.px, hist1.py), out_hit, hist1.hit);
      chk($sformatf("out_idx@(%0d,%0d)", hist1.px, hist1.py), out_idx, hist1.idx);
    end
    chk("commit", commit, m_commit);
    chk("upd_ready", upd_ready, !m_pending);
  endtask

  task automatic offer(int t, int x, int y);
    uv = 1'b1; ut = 2'(t); ux = 10'(x); uy = 10'(y);
    cycle();
    uv = 1'b0;
  endtask

  task automatic pulse_fs();
    fs = 1'b1;
    cycle();
    fs = 1'b0;
  endtask

  task automatic probe(int x, int y, bit eh, int ei, string tag);
    dx = 10'(x); dy = 10'(y); pv = 1'b1;
    cycle();
    pv = 1'b0;
    cycle();
    chk({tag, "_hit"}, out_hit, eh);
    chk({tag, "_idx"}, out_idx, ei);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, x, y, line, h;
    rst = 1'b1; fs = 1'b0; pv = 1'b0; uv = 1'b0;
    dx = '0; dy = '0; ut = '0; ux = '0; uy = '0;
    repeat (2) cycle();
    chk("rst_spr_sel", spr_sel, 0);
    chk("rst_spr_row", spr_row, 0);
    chk("rst_spr_col", spr_col, 0);
    chk("rst_out_hit", out_hit, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_upd_ready", upd_ready, 1);
    rst = 1'b0;

    // O piece at (100,200)
    offer(3, 100, 200);
    cycle();
    pulse_fs();
    chk("o_commit", commit, 1);
    probe(100, 200, 1, 7, "o_corner");
    probe(102, 202, 1, 2, "o_fill");
    probe(132, 200, 0, 0, "o_right_out");

    // I_H at (0,0)
    offer(1, 0, 0);
    pulse_fs();
    probe(48, 2, 1, 2, "ih_fill");
    probe(47, 2, 1, 7, "ih_border");
    probe(63, 15, 1, 7, "ih_last");
    probe(64, 0, 0, 0, "ih_right_out");

    // Update accepted in the same cycle as frame_start
    uv = 1'b1; ut = 2'd2; ux = 10'd630; uy = 10'd470; fs = 1'b1;
    cycle();
    uv = 1'b0; fs = 1'b0;
    chk("same_fs_commit", commit, 0);
    chk("same_fs_ready", upd_ready, 0);
    cycle();
    uv = 1'b1; ut = 2'd3; ux = 10'd0; uy = 10'd0;
    repeat (2) cycle();
    uv = 1'b0;
    chk("second_upd_ready", upd_ready, 0);
    pulse_fs();
    chk("iv_commit", commit, 1);
    dx = 10'd639; dy = 10'd479; pv = 1'b1;
    cycle();
    pv = 1'b0;
    chk("iv_spr_row", spr_row, 9);
    chk("iv_spr_col", spr_col, 9);
    chk("iv_spr_sel", spr_sel, 2);
    cycle();
    chk("iv_corner_hit", out_hit, 1);
    chk("iv_corner_idx", out_idx, 1);
    probe(5, 5, 0, 0, "iv_nowrap");

    // Reset while PENDING with the pipeline full
    offer(3, 10, 10);
    dx = 10'd12; dy = 10'd12; pv = 1'b1;
    repeat (2) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_ready", upd_ready, 1);
    pv = 1'b0;
    cycle();
    pulse_fs();
    chk("rst_mid_nocommit", commit, 0);
    dx = 10'd12; dy = 10'd12; pv = 1'b1;
    cycle();
    pv = 1'b0;
    chk("rst_mid_type_none", spr_sel, 0);
    cycle();
    chk("rst_mid_nohit", out_hit, 0);

    // Streaming lines against the model, with mid-line update offers
    for (int k = 0; k < 6; k++) begin
      t = int'($urandom_range(1, 3));
      x = (k % 2 == 1) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 660));
      y = int'($urandom_range(0, 500));
      h = (t == 1) ? 16 : ((t == 2) ? 64 : 32);
      offer(t, x, y);
      pulse_fs();
      line = ($urandom_range(0, 3) != 0) ? (y + int'($urandom_range(0, h - 1))) % 1024
                                         : int'($urandom_range(0, 479));
      for (int c = 0; c < 640; c++) begin
        dx = 10'(c); dy = 10'(line);
        pv = ($urandom_range(0, 15) != 0);
        uv = ($urandom_range(0, 63) == 0);
        ut = 2'($urandom_range(0, 3));
        ux = 10'($urandom_range(0, 1023));
        uy = 10'($urandom_range(0, 1023));
        cycle();
      end
      pv = 1'b0; uv = 1'b0;
      repeat (2) cycle();
      pulse_fs();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
